// File: rtl/bf16_vec_loader_44_if.sv
// bf16_vec_loader_44_if: element input, MAC side and result output of the BF16 vector loader
interface bf16_vec_loader_44_if #(parameter int NUM_ELEM = 12);
  logic in_valid_44, in_ready_44;
  logic [15:0] in_a_44, in_b_44;
  logic [16*NUM_ELEM-1:0] vec_a_flat_44, vec_b_flat_44;
  logic mac_start_44, mac_done_44;
  logic [15:0] mac_result_44;
  logic res_valid_44, res_ready_44;
  logic [15:0] res_data_44;
  logic [3:0] elem_count_44;
  logic busy_44, err_timeout_44;
  modport master (
    output in_valid_44, in_a_44, in_b_44, mac_done_44, mac_result_44, res_ready_44,
    input in_ready_44, vec_a_flat_44, vec_b_flat_44, mac_start_44, res_valid_44, res_data_44,
    input elem_count_44, busy_44, err_timeout_44
  );
  modport slave (
    input in_valid_44, in_a_44, in_b_44, mac_done_44, mac_result_44, res_ready_44,
    output in_ready_44, vec_a_flat_44, vec_b_flat_44, mac_start_44, res_valid_44, res_data_44,
    output elem_count_44, busy_44, err_timeout_44
  );
endinterface

// File: rtl/bf16_vec_loader_44.sv
// bf16_vec_loader_44: packs 12 BF16 pairs, runs the dot-product MAC with a watchdog, returns the result
module bf16_vec_loader_44 #(
  parameter int NUM_ELEM = 12,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [15:0] NAN_VALUE = 16'h7FC0
) (
  input logic clk_44,
  input logic rst_n_44,
  bf16_vec_loader_44_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic accept, last, hit;
  assign accept = bus.in_valid_44 && bus.in_ready_44;
  assign last = bus.elem_count_44 == 4'(NUM_ELEM - 1);
  assign hit = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_44 or negedge rst_n_44)
    if (!rst_n_44) state <= LOAD;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && last) state_nxt = RUN;
      RUN: if (bus.mac_done_44 || hit) state_nxt = DRAIN;
      DRAIN: if (!bus.mac_done_44) state_nxt = RESP;
      RESP: if (bus.res_ready_44) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end
  always_comb begin
    bus.in_ready_44 = state == LOAD;
    bus.busy_44 = state != LOAD;
  end
  always_ff @(posedge clk_44 or negedge rst_n_44)
    if (!rst_n_44) begin
      bus.vec_a_flat_44 <= '0;
      bus.vec_b_flat_44 <= '0;
      bus.elem_count_44 <= '0;
      bus.mac_start_44 <= 1'b0;
      bus.res_valid_44 <= 1'b0;
      bus.res_data_44 <= '0;
      bus.err_timeout_44 <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          bus.vec_a_flat_44[{bus.elem_count_44, 4'b0000} +: 16] <= bus.in_a_44;
          bus.vec_b_flat_44[{bus.elem_count_44, 4'b0000} +: 16] <= bus.in_b_44;
          bus.elem_count_44 <= bus.elem_count_44 + 4'd1;
          bus.mac_start_44 <= last;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          // a done arriving on the last watchdog cycle still counts as success
          if (bus.mac_done_44 || hit) begin
            bus.res_data_44 <= bus.mac_done_44 ? bus.mac_result_44 : NAN_VALUE;
            bus.err_timeout_44 <= bus.err_timeout_44 | !bus.mac_done_44;
            bus.mac_start_44 <= 1'b0;
            cnt <= '0;
          end
        end
        DRAIN: if (!bus.mac_done_44) bus.res_valid_44 <= 1'b1;
        RESP: if (bus.res_ready_44) begin
          bus.res_valid_44 <= 1'b0;
          bus.elem_count_44 <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bf16_vec_loader_44.sv
// tb_bf16_vec_loader_44: directed bench with a hand-driven MAC for the BF16 vector loader
module tb_bf16_vec_loader_44;
  logic clk = 1'b0, rst_n = 1'b0;
  int total = 0, passed = 0;
  logic [191:0] exp_a, exp_b;
  bf16_vec_loader_44_if bus();
  bf16_vec_loader_44 dut (.clk_44(clk), .rst_n_44(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input int gap);
    int n;
    repeat (gap) tick();
    bus.in_valid_44 = 1'b1;
    bus.in_a_44 = a;
    bus.in_b_44 = b;
    n = 0;
    while (!bus.in_ready_44 && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready_wait", 192'(n < 100), 192'(1));
    tick();
    bus.in_valid_44 = 1'b0;
  endtask

  task automatic run_mac(input logic [15:0] r, input int lat);
    repeat (lat) tick();
    chk("start_held", bus.mac_start_44, 1'b1);
    bus.mac_done_44 = 1'b1;
    bus.mac_result_44 = r;
    tick();
    chk("start_drop", bus.mac_start_44, 1'b0);
    chk("drain_no_valid", bus.res_valid_44, 1'b0);
    bus.mac_done_44 = 1'b0;
    tick();
    chk("res_valid", bus.res_valid_44, 1'b1);
    chk("res_data", bus.res_data_44, r);
  endtask

  task automatic take_res();
    bus.res_ready_44 = 1'b1;
    tick();
    bus.res_ready_44 = 1'b0;
    chk("res_taken", bus.res_valid_44, 1'b0);
    chk("count_clr", bus.elem_count_44, 4'd0);
    chk("ready_again", bus.in_ready_44, 1'b1);
    chk("idle", bus.busy_44, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid_44 = 1'b0;
    bus.in_a_44 = '0;
    bus.in_b_44 = '0;
    bus.mac_done_44 = 1'b0;
    bus.mac_result_44 = '0;
    bus.res_ready_44 = 1'b0;
    #2;
    chk("rst_ready", bus.in_ready_44, 1'b1);
    chk("rst_start", bus.mac_start_44, 1'b0);
    chk("rst_valid", bus.res_valid_44, 1'b0);
    chk("rst_data", bus.res_data_44, 16'h0000);
    chk("rst_count", bus.elem_count_44, 4'd0);
    chk("rst_err", bus.err_timeout_44, 1'b0);
    chk("rst_vec_a", bus.vec_a_flat_44, 192'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // 1.0 * 2.0 summed over 12 elements = 24.0
    for (int k = 0; k < 11; k++) send(16'h3F80, 16'h4000, 0);
    chk("count_11", bus.elem_count_44, 4'd11);
    chk("no_start_early", bus.mac_start_44, 1'b0);
    send(16'h3F80, 16'h4000, 0);
    chk("start_rise", bus.mac_start_44, 1'b1);
    chk("count_12", bus.elem_count_44, 4'd12);
    chk("run_not_ready", bus.in_ready_44, 1'b0);
    chk("run_busy", bus.busy_44, 1'b1);
    run_mac(16'h41C0, 3);
    tick();
    tick();
    chk("valid_hold", bus.res_valid_44, 1'b1);
    chk("data_hold", bus.res_data_44, 16'h41C0);
    take_res();
    // packing layout
    for (int k = 0; k < 12; k++) begin
      exp_a[16*k +: 16] = 16'h0100 + 16'(k);
      exp_b[16*k +: 16] = 16'h0200 + 16'(k);
      send(16'h0100 + 16'(k), 16'h0200 + 16'(k), 0);
    end
    chk("pack_a", bus.vec_a_flat_44, exp_a);
    chk("pack_b", bus.vec_b_flat_44, exp_b);
    run_mac(16'h1234, 1);
    take_res();
    send(16'h0A00, 16'h0B00, 0);
    exp_a[15:0] = 16'h0A00;
    exp_b[15:0] = 16'h0B00;
    chk("partial_a", bus.vec_a_flat_44, exp_a);
    chk("partial_b", bus.vec_b_flat_44, exp_b);
    // backpressure: random gaps while loading, stalled response
    for (int k = 1; k < 12; k++) begin
      exp_a[16*k +: 16] = 16'h0A00 + 16'(k);
      exp_b[16*k +: 16] = 16'h0B00 + 16'(k);
      send(16'h0A00 + 16'(k), 16'h0B00 + 16'(k), int'($urandom_range(0, 2)));
    end
    chk("bp_a", bus.vec_a_flat_44, exp_a);
    chk("bp_b", bus.vec_b_flat_44, exp_b);
    run_mac(16'h5555, 1);
    bus.in_valid_44 = 1'b1;
    bus.in_a_44 = 16'hFFFF;
    bus.in_b_44 = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("resp_not_ready", bus.in_ready_44, 1'b0);
      chk("resp_valid", bus.res_valid_44, 1'b1);
      chk("resp_data", bus.res_data_44, 16'h5555);
      chk("resp_count", bus.elem_count_44, 4'd12);
    end
    bus.in_valid_44 = 1'b0;
    take_res();
    chk("resp_no_load", bus.vec_a_flat_44, exp_a);
    // watchdog: MAC never answers
    for (int k = 0; k < 12; k++) send(16'(k), 16'(k), 0);
    repeat (63) tick();
    chk("to_start_63", bus.mac_start_44, 1'b1);
    chk("to_err_63", bus.err_timeout_44, 1'b0);
    tick();
    chk("to_err", bus.err_timeout_44, 1'b1);
    chk("to_start", bus.mac_start_44, 1'b0);
    chk("to_nan", bus.res_data_44, 16'h7FC0);
    chk("to_drain", bus.res_valid_44, 1'b0);
    tick();
    chk("to_valid", bus.res_valid_44, 1'b1);
    take_res();
    for (int k = 0; k < 12; k++) send(16'h3F80, 16'h3F80, 0);
    run_mac(16'h4040, 4);
    chk("err_sticky", bus.err_timeout_44, 1'b1);
    take_res();
    // MAC keeps done high after start drops
    for (int k = 0; k < 12; k++) send(16'h4000, 16'h3F80, 0);
    tick();
    bus.mac_done_44 = 1'b1;
    bus.mac_result_44 = 16'h41C0;
    tick();
    chk("dh_start", bus.mac_start_44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dh_no_valid", bus.res_valid_44, 1'b0);
      chk("dh_no_restart", bus.mac_start_44, 1'b0);
    end
    bus.mac_done_44 = 1'b0;
    tick();
    chk("dh_valid", bus.res_valid_44, 1'b1);
    chk("dh_data", bus.res_data_44, 16'h41C0);
    take_res();
    // asynchronous reset in the middle of RUN
    for (int k = 0; k < 12; k++) send(16'h2000 + 16'(k), 16'h3000, 0);
    repeat (5) tick();
    chk("ar_running", bus.mac_start_44, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_start", bus.mac_start_44, 1'b0);
    chk("ar_count", bus.elem_count_44, 4'd0);
    chk("ar_ready", bus.in_ready_44, 1'b1);
    chk("ar_busy", bus.busy_44, 1'b0);
    chk("ar_err", bus.err_timeout_44, 1'b0);
    chk("ar_data", bus.res_data_44, 16'h0000);
    chk("ar_vec", bus.vec_a_flat_44, 192'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_a[16*k +: 16] = 16'h1000 + 16'(k);
      exp_b[16*k +: 16] = 16'h1100 + 16'(k);
      send(16'h1000 + 16'(k), 16'h1100 + 16'(k), 0);
    end
    chk("post_rst_a", bus.vec_a_flat_44, exp_a);
    chk("post_rst_b", bus.vec_b_flat_44, exp_b);
    run_mac(16'h1111, 2);
    take_res();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bf16_vec_loader_44.md
Name: bf16_vec_loader_44

Overview:
- Upstream feeder and result collector for the BF16 12-element dot-product MAC (`BF16DotProduct_44` / `BF16MAC_44`).
- Accepts one BF16 (a, b) element pair per handshake and packs 12 pairs into the 192-bit flat A/B vectors.
- Drives the MAC's level-sensitive start, waits for done, and captures the 16-bit result.
- Returns the result on a valid/ready output port, with a watchdog against a hung MAC.

Parameters:
- NUM_ELEM, 12, elements per vector; fixed to match MAC flat width (192 = 16*NUM_ELEM).
- TIMEOUT_CYCLES, 64, max cycles in RUN without mac_done_44 before abort.
- NAN_VALUE, 16'h7FC0, BF16 quiet NaN returned on timeout.

Ports:
- clk_44  in  1  clock
- rst_n_44  in  1  reset, asynchronous, active-low
- in_valid_44  in  1  element pair valid
- in_ready_44  out  1  loader can accept element pair
- in_a_44  in  16  BF16 element of A
- in_b_44  in  16  BF16 element of B
- vec_a_flat_44  out  192  packed A to MAC; element k at [16k+15:16k]
- vec_b_flat_44  out  192  packed B to MAC; same layout
- mac_start_44  out  1  level start to MAC
- mac_done_44  in  1  MAC done flag (level)
- mac_result_44  in  16  MAC dot product
- res_valid_44  out  1  result valid
- res_ready_44  in  1  downstream accepts result
- res_data_44  out  16  dot-product result
- elem_count_44  out  4  elements loaded in current vector (0..12)
- busy_44  out  1  high in any state other than LOAD
- err_timeout_44  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any state): state=LOAD, vec_a/vec_b=0, elem_count=0, mac_start=0, res_valid=0, res_data=0, err_timeout=0, timeout counter=0. in_ready=1 after reset release.
- All outputs are registered except in_ready_44 and busy_44, which are decoded from state.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_a/in_b into slot elem_count and increment elem_count.
  - On the 12th accept (elem_count==11 before the edge): elem_count becomes 12, state -> RUN, mac_start=1 from the next cycle.
  - Slots not yet rewritten keep their previous-vector values.
- RUN:
  - in_ready=0; mac_start held 1; vec_a/vec_b frozen.
  - Timeout counter increments each cycle.
  - If mac_done_44=1: capture mac_result into res_data, drop mac_start, clear counter, state -> DRAIN.
  - Else if counter reaches TIMEOUT_CYCLES-1: set err_timeout=1, res_data=NAN_VALUE, drop mac_start, state -> DRAIN.
  - If mac_done and timeout coincide, done wins: result captured, no error.
- DRAIN:
  - mac_start=0.
  - Wait until mac_done_44=0; then state -> RESP with res_valid=1.
  - Guarantees the MAC has returned to IDLE before any restart.
  - Vectors stay frozen.
- RESP:
  - res_valid=1; res_data stable until accepted.
  - On res_ready, res_valid=0, elem_count=0, state -> LOAD.
  - in_ready stays 0 during RESP; no overlap of loading with the response.
- Timing:
  - Latency from 12th accept to mac_start high: 1 cycle.
  - Minimum latency from mac_done rise to res_valid: 2 cycles.
  - Throughput: one dot product per (12 + MAC latency + 3 + response-stall) cycles.
- Edge cases:
  - A mac_done already high on entry to RUN, left over from a previous run, is impossible because of DRAIN.
  - in_valid while in_ready=0 is ignored; no data lost; the upstream holds.
  - err_timeout is sticky until reset; later vectors still process normally.
  - Reset mid-RUN: mac_start drops asynchronously with reset, and the MAC shares the same reset.

Test Plan:
- Load a=1.0 (16'h3F80) and b=2.0 (16'h4000) for all 12 elements; MAC model returns 16'h41C0 → mac_start rises the cycle after the 12th accept, res_data=16'h41C0, res_valid held until res_ready, elem_count back to 0.
- Packing check: element k = a 16'h0100+k, b 16'h0200+k → vec_a_flat[16k+15:16k]=16'h0100+k for all k, exactly at mac_start rise.
- Backpressure: in_valid toggled randomly during LOAD, and res_ready held low 10 cycles in RESP → no element lost or duplicated, in_ready=0 throughout RESP, res_data stable.
- Timeout: MAC model never asserts done → after 64 RUN cycles err_timeout=1, mac_start=0, res_data=16'h7FC0; the next vector with a working MAC returns a correct result while err_timeout stays 1.
- Done held high: MAC model keeps mac_done high 3 cycles after start drops → loader stays in DRAIN, res_valid asserts 1 cycle after done falls, no second start.
- Async reset mid-RUN (after 5 RUN cycles) → all outputs at reset values immediately; a following clean 12-element load completes correctly.
